// File: rtl/mux_nby1_reg.sv
// ============================================================================
// mux_nby1_reg
// ----------------------------------------------------------------------------
// Purpose:
//   Parametrised N-channel, W-bit registered multiplexer. One of NCH input
//   words is selected and captured into a single output register. The output
//   register uses a valid/ready handshake with one cycle of latency, and
//   sustains one word per cycle. Along with each word, the module reports
//   which channel it came from. A sticky flag records any out-of-range select.
//
// Parameters:
//   WIDTH  bits per channel word
//   NCH    number of input channels (2..16)
//   SEL_W  select width, 2**SEL_W >= NCH
//
// Ports:
//   Clk       in   system clock, rising edge
//   Rst       in   asynchronous, active-high reset
//   I         in   channel words, channel k = I[k*WIDTH +: WIDTH]
//   S         in   channel select, sampled on load
//   InValid   in   I/S valid this cycle
//   InReady   out  combinational: !DValid | OutReady
//   DVal      out  registered selected word
//   DChan     out  channel index captured with DVal
//   DValid    out  DVal/DChan hold valid data
//   OutReady  in   consumer accepts DVal this cycle
//   ScanMode  in   (MUX_SCAN_EN only) 1 = internal counter picks the channel
//   SelErr    out  sticky: an out-of-range select was loaded
//
// Configuration:
//   MUX_SCAN_EN  When defined, adds the ScanMode port and an internal scan
//                counter that steps through the channels on each load.
// ============================================================================
module mux_nby1_reg #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SEL_W = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [NCH*WIDTH-1:0]   I,
    input  logic [SEL_W-1:0]       S,
    input  logic                   InValid,
    output logic                   InReady,
    output logic [WIDTH-1:0]       DVal,
    output logic [SEL_W-1:0]       DChan,
    output logic                   DValid,
    input  logic                   OutReady,
`ifdef MUX_SCAN_EN
    input  logic                   ScanMode,
`endif
    output logic                   SelErr
);

    logic             load;
    logic [SEL_W-1:0] sel;
    logic [31:0]      sel_wide;
    logic             sel_bad;
    logic [WIDTH-1:0] word;

    // The output register can accept a new word when it is empty or when
    // its current word leaves this cycle. This path uses only register state
    // and OutReady, so I and S never reach InReady.
    assign InReady = !DValid || OutReady;
    assign load    = InValid && InReady;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] scan_cnt;

    // The scan counter steps through the channels on each load in scan
    // mode. It wraps at NCH-1, so it never produces an out-of-range select.
    // In normal mode it holds, so scanning resumes where it left off.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            scan_cnt <= '0;
        end else if (load && ScanMode) begin
            if (scan_cnt == SEL_W'(NCH - 1)) begin
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    assign sel = ScanMode ? scan_cnt : S;
`else
    assign sel = S;
`endif

    // Channel selection. An explicit compare loop is used here instead of a
    // variable part-select, so an out-of-range select never indexes past the
    // top of I. Such a select yields zero.
    always_comb begin
        word     = '0;
        sel_wide = 32'(sel);
        sel_bad  = (sel_wide >= 32'(NCH));
        for (int k = 0; k < NCH; k++) begin
            if (sel == SEL_W'(k)) begin
                word = I[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register. A load takes priority over a drain, so a simultaneous
    // drain and load replaces the word without a bubble. A drain alone only
    // clears DValid. DVal and DChan keep the last word so the consumer can
    // still inspect it afterwards.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            DVal   <= '0;
            DChan  <= '0;
            DValid <= 1'b0;
            SelErr <= 1'b0;
        end else if (load) begin
            DVal   <= word;
            DChan  <= sel;
            DValid <= 1'b1;
            if (sel_bad) begin
                SelErr <= 1'b1;
            end
        end else if (DValid && OutReady) begin
            DValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nby1_reg.sv
// ============================================================================
// tb_mux_nby1_reg
// ----------------------------------------------------------------------------
// Directed self-checking bench for mux_nby1_reg. Two instances share the
// clock and reset: one with NCH=4 and all channels in range, and one with
// NCH=3 so that S=3 is an out-of-range select. All expected values are
// hand-computed constants.
// ============================================================================
module tb_mux_nby1_reg;

    logic        Clk = 1'b0;
    logic        Rst;

    logic [15:0] I;
    logic [1:0]  S;
    logic        InValid;
    logic        InReady;
    logic [3:0]  DVal;
    logic [1:0]  DChan;
    logic        DValid;
    logic        OutReady;
    logic        ScanMode;
    logic        SelErr;

    logic [11:0] I3;
    logic [1:0]  S3;
    logic        InValid3;
    logic        InReady3;
    logic [3:0]  DVal3;
    logic [1:0]  DChan3;
    logic        DValid3;
    logic        OutReady3;
    logic        ScanMode3;
    logic        SelErr3;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mux_nby1_reg #(.WIDTH(4), .NCH(4), .SEL_W(2)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .I        (I),
        .S        (S),
        .InValid  (InValid),
        .InReady  (InReady),
        .DVal     (DVal),
        .DChan    (DChan),
        .DValid   (DValid),
        .OutReady (OutReady),
`ifdef MUX_SCAN_EN
        .ScanMode (ScanMode),
`endif
        .SelErr   (SelErr)
    );

    mux_nby1_reg #(.WIDTH(4), .NCH(3), .SEL_W(2)) dut3 (
        .Clk      (Clk),
        .Rst      (Rst),
        .I        (I3),
        .S        (S3),
        .InValid  (InValid3),
        .InReady  (InReady3),
        .DVal     (DVal3),
        .DChan    (DChan3),
        .DValid   (DValid3),
        .OutReady (OutReady3),
`ifdef MUX_SCAN_EN
        .ScanMode (ScanMode3),
`endif
        .SelErr   (SelErr3)
    );

    // Advance to just after the next rising edge, a safe point for sampling.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_b2b [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

    initial begin
        Rst       = 1'b1;
        I         = {4'hD, 4'hC, 4'hB, 4'hA};
        S         = 2'd0;
        InValid   = 1'b0;
        OutReady  = 1'b1;
        ScanMode  = 1'b0;
        I3        = {4'h7, 4'h6, 4'h5};
        S3        = 2'd0;
        InValid3  = 1'b0;
        OutReady3 = 1'b1;
        ScanMode3 = 1'b0;

        step();
        step();
        Rst = 1'b0;

        // Reset state
        chk("rst_dval",   32'(DVal),   32'h0);
        chk("rst_dchan",  32'(DChan),  32'h0);
        chk("rst_dvalid", 32'(DValid), 32'h0);
        chk("rst_selerr", 32'(SelErr), 32'h0);
        chk("rst_inready", 32'(InReady), 32'h1);

        // Basic select of channel 2
        S = 2'd2;
        InValid = 1'b1;
        step();
        chk("basic_dval",   32'(DVal),   32'hC);
        chk("basic_dchan",  32'(DChan),  32'h2);
        chk("basic_dvalid", 32'(DValid), 32'h1);

        // Stall: consumer not ready, new select must not be captured
        OutReady = 1'b0;
        S = 2'd0;
        #1;
        chk("stall_inready_comb", 32'(InReady), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_inready", 32'(InReady), 32'h0);
            chk("stall_dval",    32'(DVal),    32'hC);
            chk("stall_dchan",   32'(DChan),   32'h2);
            chk("stall_dvalid",  32'(DValid),  32'h1);
        end
        OutReady = 1'b1;
        #1;
        chk("unstall_inready", 32'(InReady), 32'h1);
        step();
        chk("unstall_dval",  32'(DVal),  32'hA);
        chk("unstall_dchan", 32'(DChan), 32'h0);

        // Back-to-back loads, one word per cycle
        for (int k = 0; k < 4; k++) begin
            S = 2'(k);
            step();
            chk("b2b_dval",   32'(DVal),   32'(exp_b2b[k]));
            chk("b2b_dchan",  32'(DChan),  32'(k));
            chk("b2b_dvalid", 32'(DValid), 32'h1);
        end

        // Drain: DValid falls and the data holds
        InValid = 1'b0;
        step();
        chk("drain_dvalid", 32'(DValid), 32'h0);
        chk("drain_dval",   32'(DVal),   32'hD);
        chk("drain_dchan",  32'(DChan),  32'h3);

        // Idle hold
        step();
        chk("idle_dvalid", 32'(DValid), 32'h0);
        chk("idle_dval",   32'(DVal),   32'hD);

        // Load into an empty register even with OutReady low
        OutReady = 1'b0;
        InValid = 1'b1;
        S = 2'd1;
        step();
        chk("empty_load_dval",   32'(DVal),   32'hB);
        chk("empty_load_dvalid", 32'(DValid), 32'h1);
        InValid = 1'b0;
        step();
        chk("hold_dvalid", 32'(DValid), 32'h1);
        chk("hold_dval",   32'(DVal),   32'hB);

        // Out-of-range select on the NCH=3 instance
        chk("oor_pre_selerr", 32'(SelErr3), 32'h0);
        S3 = 2'd3;
        InValid3 = 1'b1;
        step();
        chk("oor_dval",   32'(DVal3),   32'h0);
        chk("oor_dchan",  32'(DChan3),  32'h3);
        chk("oor_dvalid", 32'(DValid3), 32'h1);
        chk("oor_selerr", 32'(SelErr3), 32'h1);
        S3 = 2'd1;
        step();
        chk("oor_after1_dval",   32'(DVal3),   32'h6);
        chk("oor_after1_selerr", 32'(SelErr3), 32'h1);
        S3 = 2'd0;
        step();
        chk("oor_after2_dval",   32'(DVal3),   32'h5);
        chk("oor_after2_selerr", 32'(SelErr3), 32'h1);
        chk("inrange_selerr",    32'(SelErr),  32'h0);

        // Reset mid-cycle with both registers holding valid data
        #2;
        Rst = 1'b1;
        #1;
        chk("midrst_dval",     32'(DVal),    32'h0);
        chk("midrst_dvalid",   32'(DValid),  32'h0);
        chk("midrst_selerr",   32'(SelErr),  32'h0);
        chk("midrst3_dval",    32'(DVal3),   32'h0);
        chk("midrst3_dvalid",  32'(DValid3), 32'h0);
        chk("midrst3_selerr",  32'(SelErr3), 32'h0);
        InValid  = 1'b0;
        InValid3 = 1'b0;
        OutReady = 1'b1;
        step();
        Rst = 1'b0;
        chk("postrst_dvalid", 32'(DValid), 32'h0);

`ifdef MUX_SCAN_EN
        // Scan mode: S is ignored and the counter walks the channels
        ScanMode = 1'b1;
        S = 2'd3;
        InValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("scan_dchan", 32'(DChan), 32'(k % 4));
            chk("scan_dval",  32'(DVal),  32'(exp_b2b[k % 4]));
        end
        ScanMode = 1'b0;
        S = 2'd2;
        step();
        chk("scan_off_dval",  32'(DVal),  32'hC);
        chk("scan_off_dchan", 32'(DChan), 32'h2);
        ScanMode = 1'b1;
        step();
        chk("scan_resume_dchan", 32'(DChan), 32'h1);
        chk("scan_resume_dval",  32'(DVal),  32'hB);
        InValid = 1'b0;

        // Scan on NCH=3 wraps at 2 and never sets SelErr
        ScanMode3 = 1'b1;
        S3 = 2'd3;
        InValid3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("scan3_dchan",  32'(DChan3),  32'(k % 3));
            chk("scan3_dval",   32'(DVal3),   32'(5 + (k % 3)));
            chk("scan3_selerr", 32'(SelErr3), 32'h0);
        end
        InValid3 = 1'b0;
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
